// File: rtl/glm_domain_pkg.sv
// glm_domain_pkg: shared constants and types for the GLM domain pipe.
//   NCH_DEFAULT  - default number of 4-bit share lanes (16 = one 64-bit PRINCE share)
//   LATENCY      - cycles from an accepted input to out_valid with no stall
//   NUM_MONO     - monomials registered per lane in stage 1
//   M_*          - bit positions of each monomial inside mono_t
// Optional feature macro: GLM_REFRESH_EN (fresh-mask refresh of s and t).
package glm_domain_pkg;

  localparam int unsigned NCH_DEFAULT = 16;
  localparam int unsigned LATENCY     = 2;
  localparam int unsigned NUM_MONO    = 14;
  localparam int unsigned X_W         = 3;
  localparam int unsigned SHARE_W     = 4;
  localparam int unsigned FRESH_W     = 8;
  localparam int unsigned MASK_W      = 4;

  // Monomial positions: degree 1, then degree 2, then degree 3.
  localparam int unsigned M_X0     = 0;
  localparam int unsigned M_X1     = 1;
  localparam int unsigned M_X2     = 2;
  localparam int unsigned M_Y      = 3;
  localparam int unsigned M_X0X1   = 4;
  localparam int unsigned M_X0X2   = 5;
  localparam int unsigned M_X1X2   = 6;
  localparam int unsigned M_X0Y    = 7;
  localparam int unsigned M_X1Y    = 8;
  localparam int unsigned M_X2Y    = 9;
  localparam int unsigned M_X0X1X2 = 10;
  localparam int unsigned M_X0X1Y  = 11;
  localparam int unsigned M_X0X2Y  = 12;
  localparam int unsigned M_X1X2Y  = 13;

  typedef logic [NUM_MONO-1:0] mono_t;

  // Stage-2 payload of one lane.
  typedef struct packed {
    logic [SHARE_W-1:0] s;
    logic [SHARE_W-1:0] t;
  } share_pair_t;

  // AND-only monomial expansion; no XOR may appear ahead of the stage-1 flops.
  function automatic mono_t monomials(input logic [X_W-1:0] xv, input logic yv);
    mono_t m;
    m           = '0;
    m[M_X0]     = xv[0];
    m[M_X1]     = xv[1];
    m[M_X2]     = xv[2];
    m[M_Y]      = yv;
    m[M_X0X1]   = xv[0] & xv[1];
    m[M_X0X2]   = xv[0] & xv[2];
    m[M_X1X2]   = xv[1] & xv[2];
    m[M_X0Y]    = xv[0] & yv;
    m[M_X1Y]    = xv[1] & yv;
    m[M_X2Y]    = xv[2] & yv;
    m[M_X0X1X2] = xv[0] & xv[1] & xv[2];
    m[M_X0X1Y]  = xv[0] & xv[1] & yv;
    m[M_X0X2Y]  = xv[0] & xv[2] & yv;
    m[M_X1X2Y]  = xv[1] & xv[2] & yv;
    return m;
  endfunction

endpackage

// File: rtl/glm_domain_lane.sv
// glm_domain_lane: datapath of one 4-bit share lane (no handshake logic).
//   clk, rst   - clock, asynchronous active-high reset (clears both stages)
//   ld1        - load stage-1 monomial register
//   ld2        - load stage-2 share register (stage1 -> stage2 transfer)
//   x[2:0], y  - lane inputs
//   fresh[7:0] - refresh randomness, only with GLM_REFRESH_EN; bits [3:0] used
//   s, t       - registered output shares
module glm_domain_lane
  import glm_domain_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ld1,
  input  logic               ld2,
  input  logic [X_W-1:0]     x,
  input  logic               y,
`ifdef GLM_REFRESH_EN
  input  logic [FRESH_W-1:0] fresh,
`endif
  output logic [SHARE_W-1:0] s,
  output logic [SHARE_W-1:0] t
);

  mono_t       m_q;
  share_pair_t comb;
  share_pair_t pair_q;

  // Stage 1: monomials only, acting as the glitch barrier before any XOR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q <= '0;
    end else if (ld1) begin
      m_q <= monomials(x, y);
    end
  end

  // Linear recombination of the registered monomials.
  always_comb begin
    comb      = '0;
    comb.s[0] = m_q[M_X0X1Y] ^ m_q[M_X1Y] ^ m_q[M_X0Y] ^ m_q[M_X1];
    comb.s[1] = m_q[M_X0X1Y] ^ m_q[M_X1X2Y] ^ m_q[M_X2Y] ^ m_q[M_X1Y];
    comb.s[2] = m_q[M_X0X2Y] ^ m_q[M_X1X2Y] ^ m_q[M_X0X2] ^ m_q[M_X2];
    comb.s[3] = m_q[M_X0X2] ^ m_q[M_X0X1Y] ^ m_q[M_X0X2Y] ^ m_q[M_X0X1X2];
    comb.t[0] = m_q[M_X0X2Y] ^ m_q[M_X0X1X2] ^ m_q[M_X1Y] ^ m_q[M_X0Y];
    comb.t[1] = m_q[M_X0X1Y] ^ m_q[M_X2Y] ^ m_q[M_X1Y];
    comb.t[2] = m_q[M_X0X1Y] ^ m_q[M_X0X2Y] ^ m_q[M_X0Y] ^ m_q[M_X1Y]
              ^ m_q[M_X1];
    comb.t[3] = m_q[M_Y] ^ m_q[M_X0X1] ^ m_q[M_X1Y] ^ m_q[M_X1X2]
              ^ m_q[M_X0X1Y] ^ m_q[M_X0X1X2] ^ m_q[M_X1X2Y];
`ifdef GLM_REFRESH_EN
    // Same mask into both shares keeps s^t invariant.
    comb.s    = comb.s ^ fresh[MASK_W-1:0];
    comb.t    = comb.t ^ fresh[MASK_W-1:0];
`endif
  end

  // Stage 2: output shares, driven straight to the ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_q <= '0;
    end else if (ld2) begin
      pair_q <= comb;
    end
  end

  assign s = pair_q.s;
  assign t = pair_q.t;

  // x0 alone appears in no output term but is still part of the stage-1 set.
  logic unused_x0;
  assign unused_x0 = m_q[M_X0];

`ifdef GLM_REFRESH_EN
  logic unused_fresh_hi;
  assign unused_fresh_hi = ^fresh[FRESH_W-1:MASK_W];
`endif

endmodule

// File: rtl/glm_domain_pipe.sv
// glm_domain_pipe: two-stage valid/ready pipe of NCH independent GLM lanes.
//   NCH        - number of 4-bit share lanes
//   clk, rst   - clock, asynchronous active-high reset
//   clr        - synchronous flush of both stages (data registers keep value)
//   in_valid / in_ready   - input handshake; x (3 bits/lane), y (1 bit/lane)
//   out_valid / out_ready - output handshake; s, t (4 bits/lane each)
//   fresh      - 8 bits/lane refresh randomness, only with GLM_REFRESH_EN
module glm_domain_pipe
  import glm_domain_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [X_W*NCH-1:0]     x,
  input  logic [NCH-1:0]         y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SHARE_W*NCH-1:0] s,
  output logic [SHARE_W*NCH-1:0] t
`ifdef GLM_REFRESH_EN
  ,
  input  logic [FRESH_W*NCH-1:0] fresh
`endif
);

  logic v1_q, v2_q;
  logic v1_d, v2_d;
  logic ready1, ready2;
  logic ld1, ld2;

  // Handshake and next-valid logic; clr kills every transfer this cycle.
  always_comb begin
    ready2   = !v2_q | out_ready;
    ready1   = !v1_q | ready2;
    in_ready = ready1 & !clr;
    ld1      = in_valid & in_ready;
    ld2      = v1_q & ready2 & !clr;
    v1_d     = v1_q;
    v2_d     = v2_q;
    if (clr) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
    end else begin
      if (ready2) v2_d = v1_q;
      if (ready1) v1_d = in_valid;
    end
  end

  // Stage valid flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
    end
  end

  assign out_valid = v2_q;

  // One datapath lane per 4-bit share nibble; lanes share only the enables.
  for (genvar c = 0; c < NCH; c++) begin : g_lane
    glm_domain_lane u_lane (
      .clk   (clk),
      .rst   (rst),
      .ld1   (ld1),
      .ld2   (ld2),
      .x     (x[X_W*c +: X_W]),
      .y     (y[c]),
`ifdef GLM_REFRESH_EN
      .fresh (fresh[FRESH_W*c +: FRESH_W]),
`endif
      .s     (s[SHARE_W*c +: SHARE_W]),
      .t     (t[SHARE_W*c +: SHARE_W])
    );
  end

endmodule

// File: doc/glm_domain_pipe.md
GLM_DOMAIN_PIPE -- requirements
Module: glm_domain_pipe

Interface
REQ-001 SHALL have parameter NCH, default 16, number of independent 4-bit share lanes (16 = one 64-bit PRINCE state share).
REQ-002 SHALL have port clk  in  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port clr  in  1  synchronous pipeline flush.
REQ-005 SHALL have port in_valid  in  1  input beat present.
REQ-006 SHALL have port in_ready  out  1  input beat accepted when in_valid&in_ready.
REQ-007 SHALL have port x  in  3*NCH  lane c uses x[3c+2:3c] (x0=LSB).
REQ-008 SHALL have port y  in  NCH  lane c uses y[c].
REQ-009 SHALL have port out_valid  out  1  output beat present.
REQ-010 SHALL have port out_ready  in  1  downstream accepts.
REQ-011 SHALL have ports s and t  out  4*NCH each  lane c drives s[4c+3:4c] and t[4c+3:4c].
REQ-012 SHALL have port fresh  in  8*NCH  refresh randomness, present only under GLM_REFRESH_EN.

Function
REQ-013 SHALL compute per lane, with juxtaposition = AND and ^ = XOR: s0=x0x1y^x1y^x0y^x1; s1=x0x1y^x1x2y^x2y^x1y; s2=x0x2y^x1x2y^x0x2^x2; s3=x0x2^x0x1y^x0x2y^x0x1x2.
REQ-014 SHALL compute t0=x0x2y^x0x1x2^x1y^x0y; t1=x0x1y^x2y^x1y; t2=x0x1y^x0x2y^x0y^x1y^x1; t3=y^x0x1^x1y^x1x2^x0x1y^x0x1x2^x1x2y.
REQ-015 SHALL register stage 1 as the 14 monomials (x0,x1,x2,y, six degree-2, four degree-3) per lane; no XOR before this register (glitch barrier).
REQ-016 SHALL register stage 2 as the XOR combinations of REQ-013/014; s,t driven directly from stage-2 flops.
REQ-017 SHALL have latency 2 cycles from accepted input to out_valid with no stall; throughput one beat per cycle.
REQ-018 SHALL set ready2 = !v2 | out_ready, ready1 = !v1 | ready2, in_ready = ready1 & !clr.
REQ-019 SHALL hold s, t, out_valid stable while out_valid & !out_ready.
REQ-020 SHALL on simultaneous output pop and input push with full pipe advance all stages in the same cycle with no bubble and no loss.
REQ-021 SHALL on clr clear v1 and v2 next edge, ignore in_valid that cycle; data registers keep value; clr dominates all transfers.
REQ-022 SHALL keep lanes fully independent; no cross-lane logic.

Reset
REQ-023 SHALL on rst clear v1, v2 and all data registers to 0 asynchronously: out_valid=0, s=0, t=0, in_ready=1 after release.
REQ-024 SHALL discard any in-flight beat when rst asserts mid-operation; no beat emitted after release until a new input is accepted.

Configuration
REQ-025 SHALL, with GLM_REFRESH_EN defined, XOR fresh[8c+3:8c] into both s and t of lane c (same mask into both), sampled on the stage1->stage2 transfer; s^t unchanged.
REQ-026 SHALL, without GLM_REFRESH_EN, omit port fresh and refresh logic; outputs exactly REQ-013/014.

Structure
REQ-027 SHALL place NCH default, LATENCY=2, monomial count 14 and monomial index constants in package glm_domain_pkg.
REQ-028 SHALL instantiate NCH copies of sub-module glm_domain_lane (monomial and combine logic of one lane); handshake/valid control lives only in glm_domain_pipe.

Verification
REQ-029 SHALL test NCH=1, x=3'b111, y=1 -> after 2 cycles s=4'b0000, t=4'b1110.
REQ-030 SHALL test x=3'b000, y=1 -> s=4'b0000, t=4'b1000; x=3'b010, y=0 -> s=4'b0001, t=4'b0100.
REQ-031 SHALL test streaming 64 random beats with out_ready random 50% -> outputs in order, match REQ-013/014 model, none lost or duplicated.
REQ-032 SHALL test full pipe, out_ready=0 for 5 cycles -> s,t,out_valid constant, in_ready=0; then out_ready=1 with in_valid=1 -> one beat per cycle, no bubble.
REQ-033 SHALL test clr and rst each asserted with 2 beats in flight -> out_valid=0 next cycle (rst: immediately), no stale beat emitted later.
REQ-034 SHALL test, with GLM_REFRESH_EN, fresh random -> per lane s^t equals unrefreshed s^t for all beats.
